uart_tx_word: RTL and testbench
===============================

# uart_tx_word

Serial transmitter that sends the miner's results back to the host over the UART link. It accepts one multi-byte word, such as a 32-bit winning nonce, through a valid/ready handshake. It sends the word as back-to-back 8N1 frames, most-significant byte first, on `txd`, and pulses `datasent` when the last stop bit is complete. It is the transmit-direction counterpart to the existing UART receive path and shares its clock and baud setting.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200 baud). Legal values are ≥ 2.
- `BYTES`, default 4: number of bytes per word. Legal values are 1..16.
- `clock`  in  1  system clock, 100 MHz, rising-edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `data_in`  in  8*BYTES  word to send. Sampled only on the acceptance edge.
- `transmit`  in  1  request strobe (valid).
- `ready`  out  1  high while idle. Acceptance occurs when `transmit & ready` at a rising edge.
- `txd`  out  1  serial line, idle high.
- `busy`  out  1  equal to `~ready`.
- `datasent`  out  1  one-cycle pulse when the whole word has been sent.

## Operation
- Reset values: `txd`=1, `ready`=1, `busy`=0, `datasent`=0. All counters and the shift register are 0.
- Word FSM:
  - IDLE: on acceptance, latch `data_in`, set byte index = BYTES-1, go to START.
  - START: drive `txd`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive `txd`=1 for CLKS_PER_BIT cycles. If byte index > 0, decrement it and go to START with no idle gap. Otherwise go to IDLE and assert `datasent`.
- Byte order: `data_in[8*BYTES-1 -: 8]` is sent first and `data_in[7:0]` last.
- Bit counter is 3 bits and byte index is 4 bits. The baud counter is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1, and wraps at each bit boundary.
- `transmit` while `busy` is ignored. There is no queueing and the latched data is not disturbed.
- `data_in` changes after acceptance have no effect.
- Reset asserted mid-frame: all outputs go to their reset values immediately (async), so `txd` goes high and aborts the frame. After reset is released the block is idle, and no partial byte is resumed.
- `txd` is driven from a flop, so there is no combinational path from any input to `txd`.

## Timing
- Let E0 be the acceptance edge. `txd` falls at E0, and `ready` falls at E0.
- Bit k of the word stream (k = 0..10*BYTES-1, counting start, data and stop bits) occupies edges E0+k·CLKS_PER_BIT up to E0+(k+1)·CLKS_PER_BIT.
- At edge E0+10·BYTES·CLKS_PER_BIT:
  - `datasent` goes high for exactly one cycle.
  - `ready` goes high in the same cycle.
  - `txd` stays 1.
- A `transmit` sampled in the `datasent` cycle is accepted at the next edge. The minimum gap between words is therefore 1 cycle of idle high.
- Latency from acceptance to the first start-bit edge is 0 cycles, since the register updates on the acceptance edge.

## Structure
- Shared package `uart_pkg` holds:
  - `CLK_FREQ_HZ` = 100_000_000
  - `BAUD` = 115200
  - derived `CLKS_PER_BIT_DEFAULT`
  - the state enum `IDLE/START/DATA/STOP`
- The existing receiver is to import the same constants.
- One sub-module, `uart_tx_byte`, is natural. It holds the single-frame serializer (start/data/stop and the baud counter) with a `start`/`done` handshake. `uart_tx_word` then holds only the byte sequencer, the word register and the `datasent` generation.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `BYTES`=4.
- **Reset:** hold `reset`=0 for 4 cycles → `txd`=1, `ready`=1, `busy`=0, `datasent`=0 throughout. Then release.
- **Single word:** send `data_in`=32'hDEADBEEF and pulse `transmit` → byte 0xDE appears on `txd` as 0,0,1,1,1,1,0,1,1,1, each bit 4 cycles. This is followed by 0xAD, 0xBE and 0xEF with no gaps. `datasent` pulses exactly 160 cycles after acceptance.
- **Request while busy:** send 32'h01020304, then at cycle 50 pulse `transmit` with 32'hFFFFFFFF → the line carries only 01,02,03,04. There is exactly one `datasent`, and `ready` stays 0 until cycle 160.
- **Back-to-back:** hold `transmit`=1 with 32'h000000AA, then 32'h55000000 → the second start bit begins 1 cycle after the first `datasent` pulse. Two `datasent` pulses occur, 161 cycles apart.
- **Reset mid-byte:** assert `reset` at cycle 22 of a word → `txd`=1 within the same cycle, `busy`=0, and no `datasent`. A new word sent after release is transmitted correctly.
- **Loopback:** connect `txd` to the existing UART receiver with matching `CLKS_PER_BIT` and send 16 random words → the received byte stream equals the sent words MSB-first, with zero framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and the frame-level state encoding for the TX and RX paths.
package uart_pkg;

  localparam int unsigned CLK_FREQ_HZ          = 100_000_000;
  localparam int unsigned BAUD                 = 115_200;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = CLK_FREQ_HZ / BAUD;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned BIT_IDX_W     = 3;
  localparam int unsigned BYTE_IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Single 8N1 frame serializer. A start request in IDLE, or on the final stop-bit
// cycle, loads byte_i and begins a start bit on that same edge (no idle gap).
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [BITS_PER_BYTE-1:0] byte_i,
  output logic                     txd_o,
  output logic                     frame_done_c
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(BITS_PER_BYTE - 1);

  tx_state_e                state_q;
  logic [BAUD_W-1:0]        baud_q;
  logic [BIT_IDX_W-1:0]     bit_q;
  logic [BITS_PER_BYTE-1:0] shift_q;
  logic                     txd_q;
  logic                     bit_end_c;

  assign bit_end_c    = (baud_q == BAUD_LAST);
  assign frame_done_c = (state_q == STOP) && bit_end_c;
  assign txd_o        = txd_q;

  // Frame FSM; the line level is registered so txd has no path from any input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shift_q <= byte_i;
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_c) begin
            baud_q  <= '0;
            txd_q   <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= BAUD_W'(baud_q + 1'b1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= BIT_IDX_W'(bit_q + 1'b1);
              txd_q   <= shift_q[1];
              shift_q <= {1'b0, shift_q[BITS_PER_BYTE-1:1]};
            end
          end else begin
            baud_q <= BAUD_W'(baud_q + 1'b1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            baud_q <= '0;
            if (start_i) begin
              shift_q <= byte_i;
              bit_q   <= '0;
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              txd_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= BAUD_W'(baud_q + 1'b1);
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_word.sv
// Multi-byte UART transmitter: accepts a word on transmit & ready, sends it
// MSB byte first as back-to-back 8N1 frames and pulses datasent at the end.
module uart_tx_word
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned BYTES        = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [8*BYTES-1:0]   data_in,
  input  logic                 transmit,
  output logic                 ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 datasent
);

  localparam int unsigned           WORD_W   = BITS_PER_BYTE * BYTES;
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES - 1);

  logic [WORD_W-1:0]        word_q;
  logic [BYTE_IDX_W-1:0]    idx_q;
  logic                     ready_q;
  logic                     busy_q;
  logic                     datasent_q;

  logic                     accept_c;
  logic                     frame_done_c;
  logic                     more_c;
  logic                     start_c;
  logic [BYTE_IDX_W-1:0]    idx_next_c;
  logic [BITS_PER_BYTE-1:0] next_byte_c;
  logic [BITS_PER_BYTE-1:0] byte_c;

  assign accept_c   = transmit & ready_q;
  assign more_c     = frame_done_c && (idx_q != '0);
  assign start_c    = accept_c | more_c;
  assign idx_next_c = BYTE_IDX_W'(idx_q - 1'b1);

  // Byte that follows the one currently on the line.
  always_comb begin
    next_byte_c = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (BYTE_IDX_W'(b) == idx_next_c) begin
        next_byte_c = word_q[BITS_PER_BYTE*b +: BITS_PER_BYTE];
      end
    end
  end

  // First byte comes straight from data_in so the start bit begins on the acceptance edge.
  assign byte_c = accept_c ? data_in[WORD_W-1 -: BITS_PER_BYTE] : next_byte_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q     <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      datasent_q <= 1'b0;
    end else begin
      datasent_q <= 1'b0;
      if (accept_c) begin
        word_q  <= data_in;
        idx_q   <= LAST_IDX;
        ready_q <= 1'b0;
        busy_q  <= 1'b1;
      end else if (frame_done_c) begin
        if (idx_q != '0) begin
          idx_q <= idx_next_c;
        end else begin
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          datasent_q <= 1'b1;
        end
      end
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign datasent = datasent_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i       (clock),
    .rst_ni      (reset),
    .start_i     (start_c),
    .byte_i      (byte_c),
    .txd_o       (txd),
    .frame_done_c(frame_done_c)
  );

endmodule

// File: tb/tb_uart_tx_word.sv
// Directed bench for uart_tx_word with CLKS_PER_BIT=4, BYTES=4; every line cycle is checked.
module tb_uart_tx_word;

  localparam int unsigned CPB = 4;
  localparam int unsigned NB  = 4;

  logic        clock;
  logic        reset;
  logic [31:0] data_in;
  logic        transmit;
  logic        ready;
  logic        txd;
  logic        busy;
  logic        datasent;

  int tests;
  int fails;

  uart_tx_word #(
    .CLKS_PER_BIT(CPB),
    .BYTES       (NB)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .data_in (data_in),
    .transmit(transmit),
    .ready   (ready),
    .txd     (txd),
    .busy    (busy),
    .datasent(datasent)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
    end
  endtask

  // Line level for bit k of the 40-bit word stream (start, 8 data LSB first, stop).
  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int         b;
    int         p;
    logic [7:0] by;
    b  = k / 10;
    p  = k % 10;
    by = w[31 - 8*b -: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  // Called just after a negedge. Optionally pokes a request mid-word, or keeps
  // transmit high with next_w so the following word is accepted right after datasent.
  task automatic run_word(input logic [31:0] w, input int poke_at, input logic [31:0] poke_w,
                          input logic hold, input logic [31:0] next_w);
    int c;
    chk("ready_before", 0, ready, 1'b1);
    data_in  = w;
    transmit = 1'b1;
    @(posedge clock);
    #1;
    if (hold) data_in = next_w;
    else transmit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < int'(CPB); j++) begin
        @(negedge clock);
        c = k * int'(CPB) + j;
        chk("txd", c, txd, exp_bit(w, k));
        chk("datasent_low", c, datasent, 1'b0);
        chk("ready_low", c, ready, 1'b0);
        chk("busy_high", c, busy, 1'b1);
        if (c == poke_at) begin
          data_in  = poke_w;
          transmit = 1'b1;
        end else if (poke_at >= 0 && c == poke_at + 1) begin
          transmit = 1'b0;
        end
      end
    end
    @(negedge clock);
    chk("datasent_pulse", 160, datasent, 1'b1);
    chk("ready_done", 160, ready, 1'b1);
    chk("busy_done", 160, busy, 1'b0);
    chk("txd_done", 160, txd, 1'b1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("idle_datasent", i, datasent, 1'b0);
      chk("idle_ready", i, ready, 1'b1);
      chk("idle_txd", i, txd, 1'b1);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b0;
    transmit = 1'b0;
    data_in  = '0;

    // Reset held for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rst_txd", i, txd, 1'b1);
      chk("rst_ready", i, ready, 1'b1);
      chk("rst_busy", i, busy, 1'b0);
      chk("rst_datasent", i, datasent, 1'b0);
    end
    reset = 1'b1;
    idle_check(2);

    // Single word.
    run_word(32'hDEADBEEF, -1, 32'h0, 1'b0, 32'h0);
    idle_check(3);

    // Request while busy is ignored.
    run_word(32'h01020304, 50, 32'hFFFFFFFF, 1'b0, 32'h0);
    idle_check(8);

    // Back-to-back: second word accepted on the edge after the first datasent.
    run_word(32'h000000AA, -1, 32'h0, 1'b1, 32'h55000000);
    run_word(32'h55000000, -1, 32'h0, 1'b0, 32'h0);
    idle_check(3);

    // Reset during data bit 4 of the first byte (line low there).
    data_in  = 32'h00FF00FF;
    transmit = 1'b1;
    @(posedge clock);
    #1;
    transmit = 1'b0;
    for (int i = 0; i <= 22; i++) @(negedge clock);
    chk("pre_abort_txd", 22, txd, 1'b0);
    reset = 1'b0;
    #1;
    chk("abort_txd", 0, txd, 1'b1);
    chk("abort_busy", 0, busy, 1'b0);
    chk("abort_ready", 0, ready, 1'b1);
    chk("abort_datasent", 0, datasent, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("abort_hold_txd", i, txd, 1'b1);
      chk("abort_hold_datasent", i, datasent, 1'b0);
    end
    reset = 1'b1;
    idle_check(2);
    run_word(32'hA5C33C5A, -1, 32'h0, 1'b0, 32'h0);
    idle_check(2);

    // Random words, whole line checked bit by bit.
    for (int n = 0; n < 16; n++) begin
      run_word($urandom, -1, 32'h0, 1'b0, 32'h0);
      idle_check(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
